// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// UART transmitter fed by a small FIFO: words queue through send/ready and leave
// as back-to-back frames with configurable width, parity and stop bits.
module uart_tx_fifo #(
  parameter int CLK        = 1,
  parameter int BAUD_RATE  = 1000000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          res,
  input  logic                          send,
  input  logic [DATA_BITS-1:0]          data,
  output logic                          ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int DIV   = CLK * 1_000_000 / BAUD_RATE;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int BIT_W = $clog2(DATA_BITS);

  if (DIV < 1) begin : g_div_err
    $error("uart_tx_fifo: CLK*1e6/BAUD_RATE must be at least 1");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_cfg_err
    $error("uart_tx_fifo: unsupported frame format");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     baud_q;
  logic [BIT_W-1:0]     bit_q;
  logic                 stop_q;
  logic                 tx_q;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;

  logic baud_last, stop_done, push, pop, shift_en;

  assign ready     = (level_q != LVL_W'(FIFO_DEPTH));
  assign push      = send && ready;
  assign baud_last = (baud_q == CNT_W'(DIV - 1));
  assign stop_done = (state_q == S_STOP) && baud_last && (stop_q == 1'(STOP_BITS - 1));
  // Pop either from idle or on the last stop cycle, so queued frames leave without a gap.
  assign pop       = (level_q != '0) && ((state_q == S_IDLE) || stop_done);
  assign shift_en  = baud_last && ((state_q == S_START) || (state_q == S_DATA));

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data;
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      shift_q  <= mem_q[rd_ptr_q];
      parity_q <= (PARITY == 1) ? ~^mem_q[rd_ptr_q] : ^mem_q[rd_ptr_q];
    end else if (shift_en) begin
      shift_q <= shift_q >> 1;
    end
  end

  // shift_q[0] always holds the next data bit to drive once START/DATA ends.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          baud_q <= '0;
          tx_q   <= 1'b1;
          if (pop) begin
            state_q <= S_START;
            tx_q    <= 1'b0;
          end
        end
        S_START: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= S_DATA;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == BIT_W'(DATA_BITS - 1)) begin
              if (PARITY != 0) begin
                state_q <= S_PARITY;
                tx_q    <= parity_q;
              end else begin
                state_q <= S_STOP;
                stop_q  <= 1'b0;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + 1'b1;
              tx_q  <= shift_q[0];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (baud_last) begin
            baud_q  <= '0;
            state_q <= S_STOP;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            if (stop_done) begin
              if (pop) begin
                state_q <= S_START;
                tx_q    <= 1'b0;
              end else begin
                state_q <= S_IDLE;
                tx_q    <= 1'b1;
              end
            end else begin
              stop_q <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx    = tx_q;
  assign busy  = (state_q != S_IDLE);
  assign level = level_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
// Directed bench for uart_tx_fifo: three configurations (8N1, 8E2, 5O1 at one clk per bit)
// checked cycle by cycle against hand-written frames.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  logic       send_a, send_b, send_c;
  logic [7:0] data_a, data_b;
  logic [4:0] data_c;
  logic       ready_a, tx_a, busy_a;
  logic       ready_b, tx_b, busy_b;
  logic       ready_c, tx_c, busy_c;
  logic [2:0] level_a, level_b, level_c;

  uart_tx_fifo #(.CLK(50), .BAUD_RATE(5_000_000), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .res(res), .send(send_a), .data(data_a),
    .ready(ready_a), .tx(tx_a), .busy(busy_a), .level(level_a));

  uart_tx_fifo #(.CLK(50), .BAUD_RATE(5_000_000), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .res(res), .send(send_b), .data(data_b),
    .ready(ready_b), .tx(tx_b), .busy(busy_b), .level(level_b));

  uart_tx_fifo #(.CLK(1), .BAUD_RATE(1_000_000), .DATA_BITS(5), .PARITY(1),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .res(res), .send(send_c), .data(data_c),
    .ready(ready_c), .tx(tx_c), .busy(busy_c), .level(level_c));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic get_tx(input int inst);
    case (inst)
      0:       return tx_a;
      1:       return tx_b;
      default: return tx_c;
    endcase
  endfunction

  function automatic logic get_busy(input int inst);
    case (inst)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  // Called from a negedge; pushes one word at the next rising edge.
  task automatic push(input int inst, input logic [7:0] v);
    case (inst)
      0:       begin send_a = 1'b1; data_a = v;      end
      1:       begin send_b = 1'b1; data_b = v;      end
      default: begin send_c = 1'b1; data_c = v[4:0]; end
    endcase
    @(posedge clk); @(negedge clk);
    send_a = 1'b0; send_b = 1'b0; send_c = 1'b0;
  endtask

  // Called at the negedge right after the push edge; bits[i] is the i-th line bit.
  task automatic frame_check(input string tag, input int inst, input logic [15:0] bits,
                             input int nbits, input int div);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < div; c++) begin
        @(posedge clk); @(negedge clk);
        check(tag, get_tx(inst), bits[b]);
        if (c == 0) check({tag, "_busy"}, get_busy(inst), 1'b1);
      end
    end
    @(posedge clk); @(negedge clk);
    check({tag, "_busy_end"}, get_busy(inst), 1'b0);
    check({tag, "_idle_tx"}, get_tx(inst), 1'b1);
  endtask

  int exp_lvl [8] = '{1, 1, 2, 3, 4, 4, 4, 4};
  int exp_rdy [8] = '{1, 1, 1, 1, 0, 0, 0, 0};

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    int j, w, b;
    logic [31:0] word;
    logic e;
    res = 1'b0;
    send_a = 1'b0; send_b = 1'b0; send_c = 1'b0;
    data_a = '0; data_b = '0; data_c = '0;

    // Asynchronous reset before any clock edge.
    #2 res = 1'b1;
    #1;
    check("rst_tx_a", tx_a, 1'b1);       check("rst_ready_a", ready_a, 1'b1);
    check("rst_busy_a", busy_a, 1'b0);   check("rst_level_a", level_a, 3'd0);
    check("rst_tx_b", tx_b, 1'b1);       check("rst_ready_b", ready_b, 1'b1);
    check("rst_busy_b", busy_b, 1'b0);   check("rst_level_b", level_b, 3'd0);
    check("rst_tx_c", tx_c, 1'b1);       check("rst_ready_c", ready_c, 1'b1);
    check("rst_busy_c", busy_c, 1'b0);   check("rst_level_c", level_c, 3'd0);
    @(negedge clk);
    res = 1'b0;
    repeat (3) @(negedge clk);

    // 8N1, DIV=10, 0x67.
    push(0, 8'h67);
    check("t2_level", level_a, 3'd1);
    check("t2_busy_pre", busy_a, 1'b0);
    frame_check("t2_tx", 0, 16'b0000_0010_1100_1110, 10, 10);
    check("t2_level_end", level_a, 3'd0);

    // 8E2, DIV=10, 0x67: parity 1, two stop bits.
    push(1, 8'h67);
    frame_check("t3_tx", 1, 16'b0000_1110_1100_1110, 12, 10);

    // 5O1, DIV=1, 5'b10110: parity 0.
    push(2, 8'h16);
    frame_check("t6_tx", 2, 16'b0000_0000_1010_1100, 8, 1);

    // Hold send for 8 cycles with data 0..7 into a 4-deep FIFO.
    for (int k = 0; k < 502; k++) begin
      send_a = (k < 8);
      data_a = k[7:0];
      @(posedge clk); @(negedge clk);
      if (k < 8) begin
        check("t4_level", level_a, exp_lvl[k]);
        check("t4_ready", ready_a, exp_rdy[k]);
      end
      if (k >= 1 && k <= 500) begin
        j = k - 1;
        w = j / 100;
        b = (j % 100) / 10;
        word = w;
        if (b == 0)      e = 1'b0;
        else if (b == 9) e = 1'b1;
        else             e = word[b-1];
        check("t4_tx", tx_a, e);
        if (j % 100 == 0) check("t4_busy", busy_a, 1'b1);
      end
      if (k == 501) begin
        check("t4_busy_end", busy_a, 1'b0);
        check("t4_level_end", level_a, 3'd0);
        check("t4_tx_end", tx_a, 1'b1);
      end
    end
    send_a = 1'b0;

    // Reset during data bit 3 with two words queued.
    send_a = 1'b1; data_a = 8'h00;
    @(posedge clk); @(negedge clk);
    data_a = 8'hFF;
    @(posedge clk); @(negedge clk);
    data_a = 8'h55;
    @(posedge clk); @(negedge clk);
    send_a = 1'b0;
    check("t5_level_q", level_a, 3'd2);
    repeat (44) begin @(posedge clk); @(negedge clk); end
    check("t5_tx_bit3", tx_a, 1'b0);
    check("t5_busy_pre", busy_a, 1'b1);
    #2 res = 1'b1;
    #1;
    check("t5_rst_tx", tx_a, 1'b1);
    check("t5_rst_level", level_a, 3'd0);
    check("t5_rst_busy", busy_a, 1'b0);
    check("t5_rst_ready", ready_a, 1'b1);
    @(negedge clk);
    res = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); @(negedge clk);
      check("t5_post_tx", tx_a, 1'b1);
      check("t5_post_busy", busy_a, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
